// File: rtl/nnl3_act_ser.sv
// Layer-3 activation and serializer: captures nine layer results per frame, applies
// ReLU / leaky-ReLU, streams them over valid/ready and reports the frame's arg-max.
module nnl3_act_ser #(
    parameter int ACT_MODE    = 1,
    parameter int LEAKY_SHIFT = 3,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data1,
    input  logic signed [DATA_W-1:0] in_data2,
    input  logic signed [DATA_W-1:0] in_data3,
    input  logic signed [DATA_W-1:0] in_data4,
    input  logic signed [DATA_W-1:0] in_data5,
    input  logic signed [DATA_W-1:0] in_data6,
    input  logic signed [DATA_W-1:0] in_data7,
    input  logic signed [DATA_W-1:0] in_data8,
    input  logic signed [DATA_W-1:0] in_data9,
    output logic                     in_drop,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [3:0]               out_idx,
    output logic                     out_last,
    output logic signed [DATA_W-1:0] max_val,
    output logic [3:0]               max_idx,
    output logic                     max_valid
);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                   state, state_nxt;
    logic                     in_valid_d;
    logic                     cap_edge;
    logic                     accept;
    logic signed [DATA_W-1:0] buf_q [9];
    logic [3:0]               idx;
    logic [3:0]               idx_m1;
    logic signed [DATA_W-1:0] cur_act;
    logic signed [DATA_W-1:0] run_max;
    logic [3:0]               run_idx;
    logic                     take_new;
    logic signed [DATA_W-1:0] max_nxt;
    logic [3:0]               max_idx_nxt;

    // Magnitude never grows, so the result always fits back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] x);
        if (!x[DATA_W-1])
            return x;
        else if (ACT_MODE == 0)
            return '0;
        else
            return x >>> LEAKY_SHIFT;
    endfunction

    assign cap_edge    = in_valid && !in_valid_d;
    assign accept      = (state == STREAM) && out_ready;
    assign idx_m1      = idx - 4'd1;
    assign cur_act     = act_fn(buf_q[idx_m1]);
    // Strict greater-than keeps the lower index on ties.
    assign take_new    = (idx == 4'd1) || (cur_act > run_max);
    assign max_nxt     = take_new ? cur_act : run_max;
    assign max_idx_nxt = take_new ? idx : run_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        max_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cap_edge)
                    state_nxt = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = cur_act;
                out_idx   = idx;
                out_last  = (idx == 4'd9);
                if (accept && idx == 4'd9)
                    state_nxt = FINISH;
            end
            FINISH: begin
                busy      = 1'b1;
                max_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // max_val/max_idx are loaded on the final accept so they are already valid
    // during the FINISH cycle that pulses max_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_valid_d <= 1'b0;
            in_drop    <= 1'b0;
            idx        <= 4'd1;
            run_max    <= '0;
            run_idx    <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            for (int i = 0; i < 9; i++)
                buf_q[i] <= '0;
        end else begin
            in_valid_d <= in_valid;
            in_drop    <= cap_edge && (state != IDLE);
            if (state == IDLE && cap_edge) begin
                buf_q[0] <= in_data1;
                buf_q[1] <= in_data2;
                buf_q[2] <= in_data3;
                buf_q[3] <= in_data4;
                buf_q[4] <= in_data5;
                buf_q[5] <= in_data6;
                buf_q[6] <= in_data7;
                buf_q[7] <= in_data8;
                buf_q[8] <= in_data9;
                idx      <= 4'd1;
            end
            if (accept) begin
                run_max <= max_nxt;
                run_idx <= max_idx_nxt;
                if (idx == 4'd9) begin
                    max_val <= max_nxt;
                    max_idx <= max_idx_nxt;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nnl3_act_ser.sv
// Bench for nnl3_act_ser: a leaky-mode and a ReLU-mode instance share stimulus and are
// checked against a plain-arithmetic model of the activation and arg-max.
module tb_nnl3_act_ser;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0;
    logic signed [15:0] d [9];
    logic               out_ready = 1'b1;

    logic               in_drop, busy, out_valid, out_last, max_valid;
    logic signed [15:0] out_data, max_val;
    logic [3:0]         out_idx, max_idx;
    logic               in_drop_r, busy_r, out_valid_r, out_last_r, max_valid_r;
    logic signed [15:0] out_data_r, max_val_r;
    logic [3:0]         out_idx_r, max_idx_r;

    nnl3_act_ser #(.ACT_MODE(1), .LEAKY_SHIFT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_data1(d[0]), .in_data2(d[1]), .in_data3(d[2]), .in_data4(d[3]), .in_data5(d[4]),
        .in_data6(d[5]), .in_data7(d[6]), .in_data8(d[7]), .in_data9(d[8]),
        .in_drop(in_drop), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .max_val(max_val), .max_idx(max_idx), .max_valid(max_valid)
    );

    nnl3_act_ser #(.ACT_MODE(0), .LEAKY_SHIFT(3)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_data1(d[0]), .in_data2(d[1]), .in_data3(d[2]), .in_data4(d[3]), .in_data5(d[4]),
        .in_data6(d[5]), .in_data7(d[6]), .in_data8(d[7]), .in_data9(d[8]),
        .in_drop(in_drop_r), .busy(busy_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_idx(out_idx_r), .out_last(out_last_r),
        .max_val(max_val_r), .max_idx(max_idx_r), .max_valid(max_valid_r)
    );

    int n_checks = 0;
    int n_err    = 0;

    int obs_data[$], obs_idx[$], obs_last[$], obs_data_r[$];
    int got_max, got_max_idx, got_max_r, got_max_idx_r;
    int max_cyc, first_cyc, idle_cyc, drops, unstable, max_pulses;
    bit timeout;

    function automatic int act_model(input int x, input int mode);
        int q;
        if (x >= 0) return x;
        if (mode == 0) return 0;
        q = x / 8;
        if (q * 8 != x) q = q - 1;
        return q;
    endfunction

    function automatic int model_max(input int v[9], input int mode, output int mi);
        int mv;
        mv = act_model(v[0], mode);
        mi = 1;
        for (int i = 1; i < 9; i++)
            if (act_model(v[i], mode) > mv) begin
                mv = act_model(v[i], mode);
                mi = i + 1;
            end
        return mv;
    endfunction

    // rmode: 0 ready always, 1 toggling 1,0,1,0..., 2 random.
    task automatic stream_frame(input int v[9], input int rmode, input int plen, input int second_at);
        logic        prev_stall;
        int          pd, pi;
        logic        pl;
        obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_data_r.delete();
        got_max = 0; got_max_idx = 0; got_max_r = 0; got_max_idx_r = 0;
        max_cyc = -1; first_cyc = -1; idle_cyc = -1; drops = 0; unstable = 0; max_pulses = 0;
        timeout = 1'b1;
        prev_stall = 1'b0; pd = 0; pi = 0; pl = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) d[i] = 16'(v[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (prev_stall && (out_valid !== 1'b1 || int'(out_data) != pd ||
                               int'(out_idx) != pi || out_last !== pl))
                unstable++;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (max_valid) begin
                max_pulses++;
                got_max = int'(max_val); got_max_idx = int'(max_idx); max_cyc = cyc;
            end
            if (max_valid_r) begin
                got_max_r = int'(max_val_r); got_max_idx_r = int'(max_idx_r);
            end
            if (in_drop) drops++;
            if (!busy && cyc > 1) begin
                idle_cyc = cyc;
                timeout  = 1'b0;
                break;
            end
            in_valid = (cyc < plen) || (cyc == second_at);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                obs_data.push_back(int'(out_data));
                obs_idx.push_back(int'(out_idx));
                obs_last.push_back(int'(out_last));
            end
            if (out_valid_r && out_ready) obs_data_r.push_back(int'(out_data_r));
            prev_stall = out_valid && !out_ready;
            pd = int'(out_data); pi = int'(out_idx); pl = out_last;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (timeout) begin
            n_checks++; n_err++;
            $display("FAIL frame_timeout: busy never dropped within 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, out_valid, out_last, in_drop, max_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {busy, out_valid, out_last, in_drop, max_valid});
        end
        n_checks++;
        if (out_data !== 16'sd0 || out_idx !== 4'd0) begin
            n_err++; $display("FAIL reset_out: data=%0d idx=%0d want 0 0", out_data, out_idx);
        end
        n_checks++;
        if (max_val !== 16'sd0 || max_idx !== 4'd0) begin
            n_err++; $display("FAIL reset_max: val=%0d idx=%0d want 0 0", max_val, max_idx);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int v[9], input bit check_relu);
        int exp_mi, exp_mv, exp_mi_r, exp_mv_r;
        exp_mv = model_max(v, 1, exp_mi);
        exp_mv_r = model_max(v, 0, exp_mi_r);
        n_checks++;
        if (obs_data.size() != 9) begin
            n_err++; $display("FAIL %s_count: got %0d elements want 9", name, obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 9; i++) begin
            n_checks++;
            if (obs_data[i] != act_model(v[i], 1) || obs_idx[i] != i + 1 || obs_last[i] != (i == 8 ? 1 : 0)) begin
                n_err++;
                $display("FAIL %s_elem%0d: data=%0d idx=%0d last=%0d want %0d %0d %0d", name, i + 1,
                         obs_data[i], obs_idx[i], obs_last[i], act_model(v[i], 1), i + 1, (i == 8 ? 1 : 0));
            end
        end
        n_checks++;
        if (got_max != exp_mv || got_max_idx != exp_mi || max_pulses != 1) begin
            n_err++; $display("FAIL %s_max: val=%0d idx=%0d pulses=%0d want %0d %0d 1", name,
                              got_max, got_max_idx, max_pulses, exp_mv, exp_mi);
        end
        if (check_relu) begin
            n_checks++;
            if (obs_data_r.size() != 9) begin
                n_err++; $display("FAIL %s_relu_count: got %0d want 9", name, obs_data_r.size());
            end
            for (int i = 0; i < obs_data_r.size() && i < 9; i++) begin
                n_checks++;
                if (obs_data_r[i] != act_model(v[i], 0)) begin
                    n_err++; $display("FAIL %s_relu_elem%0d: got %0d want %0d", name, i + 1,
                                      obs_data_r[i], act_model(v[i], 0));
                end
            end
            n_checks++;
            if (got_max_r != exp_mv_r || got_max_idx_r != exp_mi_r) begin
                n_err++; $display("FAIL %s_relu_max: val=%0d idx=%0d want %0d %0d", name,
                                  got_max_r, got_max_idx_r, exp_mv_r, exp_mi_r);
            end
        end
    endtask

    task automatic test_leaky_vector();
        int v[9] = '{100, -80, 5, 0, -1, 300, 300, -16, 7};
        int exp_leaky[9] = '{100, -10, 5, 0, -1, 300, 300, -2, 7};
        int exp_relu[9]  = '{100, 0, 5, 0, 0, 300, 300, 0, 7};
        stream_frame(v, 0, 1, -1);
        for (int i = 0; i < 9 && i < obs_data.size() && i < obs_data_r.size(); i++) begin
            n_checks++;
            if (obs_data[i] != exp_leaky[i] || obs_data_r[i] != exp_relu[i]) begin
                n_err++; $display("FAIL vec_elem%0d: leaky=%0d relu=%0d want %0d %0d", i + 1,
                                  obs_data[i], obs_data_r[i], exp_leaky[i], exp_relu[i]);
            end
        end
        check_frame("vec", v, 1'b1);
        n_checks++;
        if (got_max != 300 || got_max_idx != 6 || got_max_r != 300 || got_max_idx_r != 6) begin
            n_err++; $display("FAIL vec_tie_max: %0d@%0d relu %0d@%0d want 300@6", got_max, got_max_idx,
                              got_max_r, got_max_idx_r);
        end
        n_checks++;
        if (first_cyc != 1 || max_cyc != 10 || idle_cyc != 11 || drops != 0) begin
            n_err++; $display("FAIL vec_timing: first=%0d max=%0d idle=%0d drops=%0d want 1 10 11 0",
                              first_cyc, max_cyc, idle_cyc, drops);
        end
    endtask

    task automatic test_all_negative();
        int v[9];
        for (int i = 0; i < 9; i++) v[i] = -8 * (i + 1);
        stream_frame(v, 0, 1, -1);
        for (int i = 0; i < 9 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] != -(i + 1)) begin
                n_err++; $display("FAIL neg_elem%0d: got %0d want %0d", i + 1, obs_data[i], -(i + 1));
            end
        end
        check_frame("neg", v, 1'b1);
        n_checks++;
        if (got_max != -1 || got_max_idx != 1) begin
            n_err++; $display("FAIL neg_max: %0d@%0d want -1@1", got_max, got_max_idx);
        end
    endtask

    task automatic test_backpressure();
        int v[9];
        for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 65535) - 32768;
        stream_frame(v, 1, 1, -1);
        check_frame("bp", v, 1'b1);
        n_checks++;
        if (unstable != 0 || max_cyc != 18) begin
            n_err++; $display("FAIL bp_stall: unstable=%0d max_cyc=%0d want 0 18", unstable, max_cyc);
        end
    endtask

    task automatic test_drop();
        int v[9];
        for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 65535) - 32768;
        stream_frame(v, 0, 2, 5);
        check_frame("drop", v, 1'b0);
        n_checks++;
        if (drops != 1) begin
            n_err++; $display("FAIL drop_count: got %0d want 1", drops);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL drop_recapture: busy=%b want 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int v[9];
        bit found = 1'b0;
        for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 65535) - 32768;
        @(negedge clk);
        for (int i = 0; i < 9; i++) d[i] = 16'(v[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid && out_idx == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_err++; $display("FAIL rst_reach4: element 4 never presented");
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, out_valid, out_last, max_valid} !== 4'b0 || out_data !== 16'sd0 ||
            out_idx !== 4'd0 || max_val !== 16'sd0 || max_idx !== 4'd0) begin
            n_err++; $display("FAIL rst_async: busy=%b valid=%b data=%0d idx=%0d max=%0d want all 0",
                              busy, out_valid, out_data, out_idx, max_val);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_discard: busy=%b valid=%b want 0 0", busy, out_valid);
        end
        for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 65535) - 32768;
        stream_frame(v, 0, 1, -1);
        check_frame("rst_fresh", v, 1'b1);
    endtask

    task automatic test_random();
        int v[9];
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 65535) - 32768;
            if (f == 0) v[$urandom_range(0, 8)] = -32768;
            stream_frame(v, 2, 1, -1);
            check_frame("rand", v, 1'b1);
            n_checks++;
            if (unstable != 0 || drops != 0) begin
                n_err++; $display("FAIL rand_stall: unstable=%0d drops=%0d want 0 0", unstable, drops);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) d[i] = '0;
        test_reset();
        test_leaky_vector();
        test_all_negative();
        test_backpressure();
        test_drop();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
